// File: rtl/loader_pkg.sv
// Shared constants for the UART boot loader: sync marker default, loader FSM and RX FSM encodings.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHK    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // States in which a frame is in progress (framing errors abort these).
    function automatic logic is_loading(input logic [2:0] s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling timer, one-cycle rx_valid / rx_ferr pulses.
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_s)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// UART boot loader: SYNC, LEN_LO, LEN_HI, 4*N bytes packed little-endian into BRAM port A writes.
// Define CHECKSUM_EN to require a trailing XOR checksum byte over the LEN and data bytes.
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned ADDR_W    = 13,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              cpu_rst_n,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned IDX_W        = ADDR_W - 2;
    localparam logic [16:0] CAPACITY     = 17'(2 ** IDX_W);
`ifdef CHECKSUM_EN
    localparam logic [2:0]  ST_AFTER     = ST_CHK;
`else
    localparam logic [2:0]  ST_AFTER     = ST_DONE;
`endif

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;
    logic [2:0]       state;
    logic [15:0]      word_cnt;
    logic [IDX_W-1:0] index;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift;
    logic [15:0]      len_full;
    logic             last_word;
`ifdef CHECKSUM_EN
    logic [7:0]       csum;
`endif

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    assign len_full  = {rx_byte, word_cnt[7:0]};
    // Compared one bit wider than the index so a full-capacity image cannot wrap before the check.
    assign last_word = (17'(index) + 17'd1) == {1'b0, word_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            index     <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            cpu_rst_n <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we    <= '0;
            busy      <= is_loading(state);
            done      <= (state == ST_DONE);
            err       <= (state == ST_ERROR);
            cpu_rst_n <= (state == ST_DONE);

            if (rx_ferr && is_loading(state)) begin
                state <= ST_ERROR;
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state    <= ST_LEN_LO;
                            index    <= '0;
                            byte_cnt <= '0;
`ifdef CHECKSUM_EN
                            csum     <= '0;
`endif
                        end
                    end
                    ST_LEN_LO: begin
                        word_cnt[7:0] <= rx_byte;
                        state         <= ST_LEN_HI;
`ifdef CHECKSUM_EN
                        csum          <= csum ^ rx_byte;
`endif
                    end
                    ST_LEN_HI: begin
                        word_cnt[15:8] <= rx_byte;
`ifdef CHECKSUM_EN
                        csum           <= csum ^ rx_byte;
`endif
                        if (17'(len_full) > CAPACITY)
                            state <= ST_ERROR;
                        else if (len_full == 16'd0)
                            state <= ST_AFTER;
                        else
                            state <= ST_DATA;
                    end
                    ST_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {rx_byte, shift[23:8]};
`ifdef CHECKSUM_EN
                        csum     <= csum ^ rx_byte;
`endif
                        if (byte_cnt == 2'd3) begin
                            mem_we   <= 4'hF;
                            mem_din  <= {rx_byte, shift};
                            mem_addr <= {index, 2'b00};
                            index    <= index + IDX_W'(1);
                            if (last_word)
                                state <= ST_AFTER;
                        end
                    end
`ifdef CHECKSUM_EN
                    ST_CHK: begin
                        state <= (rx_byte == csum) ? ST_DONE : ST_ERROR;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Table-driven bench for uart_mem_loader at 10 clocks/bit; a second 4-word instance covers full capacity.
module tb_uart_mem_loader;

    localparam int CPB = 10;

    logic        clk;
    logic        rst_n;
    logic        rx;

    logic        cpu_rst_n, busy, done, err;
    logic [3:0]  mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din;

    logic        s_cpu_rst_n, s_busy, s_done, s_err;
    logic [3:0]  s_we;
    logic [3:0]  s_addr;
    logic [31:0] s_din;

    uart_mem_loader #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(13), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .cpu_rst_n(cpu_rst_n), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done), .err(err)
    );

    uart_mem_loader #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .ADDR_W(4), .SYNC_BYTE(8'hA5)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .rx(rx), .cpu_rst_n(s_cpu_rst_n), .mem_we(s_we),
        .mem_addr(s_addr), .mem_din(s_din), .busy(s_busy), .done(s_done), .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [12:0] wr_addr[$];
    logic [31:0] wr_din[$];
    int          long_cnt = 0;
    int          bad_we_cnt = 0;
    logic [3:0]  prev_we = '0;
    int          s_wr_cnt = 0;
    logic [3:0]  s_last_addr = '0;
    logic [31:0] s_last_din = '0;
    logic [3:0]  s_prev_we = '0;

    always @(negedge clk) begin
        if (mem_we !== 4'h0) begin
            wr_addr.push_back(mem_addr);
            wr_din.push_back(mem_din);
            if (mem_we !== 4'hF) bad_we_cnt++;
            if (prev_we !== 4'h0) long_cnt++;
        end
        prev_we = mem_we;
        if (s_we !== 4'h0) begin
            s_wr_cnt++;
            s_last_addr = s_addr;
            s_last_din  = s_din;
            if (s_prev_we !== 4'h0) long_cnt++;
        end
        s_prev_we = s_we;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [255:0] bytes;     // first byte at the MSB end
        int           n;
        int           bad_idx;   // byte sent with stop bit 0, -1 for none
        int           cs_start;  // first byte covered by the appended checksum, -1 for none
        int           exp_wr;
        logic [12:0]  first_addr;
        logic [31:0]  first_din;
        logic [12:0]  last_addr;
        logic [31:0]  last_din;
        logic         exp_done;
        logic         exp_err;
    } vec_t;

    function automatic logic [255:0] left(input logic [255:0] v, input int n);
        return v << (256 - 8 * n);
    endfunction

    vec_t        vecs[7];
    int          nvec;
    int          base;
    int          cnt;
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [7:0]  k;

    initial begin
        vecs[0] = '{left(256'hA50200_13000000_B7001000, 11), 11, -1, 1, 2,
                    13'h0, 32'h0000_0013, 13'h4, 32'h0010_00B7, 1'b1, 1'b0};
        vecs[1] = '{left(256'h00FFA50000, 5), 5, -1, 3, 0,
                    13'h0, 32'h0, 13'h0, 32'h0, 1'b1, 1'b0};
        vecs[2] = '{left(256'hA50100_1122334455, 8), 8, 5, -1, 0,
                    13'h0, 32'h0, 13'h0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{left(256'hA50100_EFBEADDE, 7), 7, -1, 1, 1,
                    13'h0, 32'hDEAD_BEEF, 13'h0, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[4] = '{left(256'hA50108, 3), 3, -1, -1, 0,
                    13'h0, 32'h0, 13'h0, 32'h0, 1'b0, 1'b1};
        nvec = 5;
`ifdef CHECKSUM_EN
        vecs[5] = '{left(256'hA50100_11223344_45, 8), 8, -1, -1, 1,
                    13'h0, 32'h4433_2211, 13'h0, 32'h4433_2211, 1'b1, 1'b0};
        vecs[6] = '{left(256'hA50100_11223344_08, 8), 8, -1, -1, 1,
                    13'h0, 32'h4433_2211, 13'h0, 32'h4433_2211, 1'b0, 1'b1};
        nvec = 7;
`endif

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("reset_mem_we",    32'(mem_we),    32'd0);
        chk("reset_mem_addr",  32'(mem_addr),  32'd0);
        chk("reset_mem_din",   mem_din,        32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_done",      32'(done),      32'd0);
        chk("reset_err",       32'(err),       32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_no_write", 32'(wr_addr.size()), 32'd0);

        for (int i = 0; i < nvec; i++) begin
            base = wr_addr.size();
            cs   = '0;
            for (int j = 0; j < vecs[i].n; j++) begin
                b = vecs[i].bytes[255 - 8 * j -: 8];
                if (vecs[i].cs_start >= 0 && j >= vecs[i].cs_start) cs = cs ^ b;
                send_byte(b, j != vecs[i].bad_idx);
            end
`ifdef CHECKSUM_EN
            if (vecs[i].cs_start >= 0) send_byte(cs, 1'b1);
`endif
            settle();
            cnt = wr_addr.size() - base;
            chk($sformatf("v%0d_writes", i), 32'(cnt), 32'(vecs[i].exp_wr));
            if (cnt > 0 && vecs[i].exp_wr > 0) begin
                chk($sformatf("v%0d_first_addr", i), 32'(wr_addr[base]), 32'(vecs[i].first_addr));
                chk($sformatf("v%0d_first_din", i), wr_din[base], vecs[i].first_din);
                chk($sformatf("v%0d_last_addr", i), 32'(wr_addr[base + cnt - 1]), 32'(vecs[i].last_addr));
                chk($sformatf("v%0d_last_din", i), wr_din[base + cnt - 1], vecs[i].last_din);
            end
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_cpu_rst_n", i), 32'(cpu_rst_n), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // Full capacity on the 4-word instance: last write lands on the top word.
        base = wr_addr.size();
        cnt  = s_wr_cnt;
        cs   = 8'h04;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            k  = 8'(j);
            cs = cs ^ k;
            send_byte(k, 1'b1);
        end
`ifdef CHECKSUM_EN
        send_byte(cs, 1'b1);
`endif
        settle();
        chk("cap_small_writes", 32'(s_wr_cnt - cnt), 32'd4);
        chk("cap_small_last_addr", 32'(s_last_addr), 32'hC);
        chk("cap_small_last_din", s_last_din, 32'h100F_0E0D);
        chk("cap_small_done", 32'(s_done), 32'd1);
        chk("cap_small_err", 32'(s_err), 32'd0);
        chk("cap_main_writes", 32'(wr_addr.size() - base), 32'd4);

        // One word over capacity on the small instance; the main instance accepts it.
        base = wr_addr.size();
        cnt  = s_wr_cnt;
        cs   = 8'h05;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (5) @(negedge clk);
        chk("over_small_err_after_len", 32'(s_err), 32'd1);
        for (int j = 1; j <= 20; j++) begin
            k  = 8'(j);
            cs = cs ^ k;
            send_byte(k, 1'b1);
        end
`ifdef CHECKSUM_EN
        send_byte(cs, 1'b1);
`endif
        settle();
        chk("over_small_writes", 32'(s_wr_cnt - cnt), 32'd0);
        chk("over_small_cpu_rst_n", 32'(s_cpu_rst_n), 32'd0);
        chk("over_main_writes", 32'(wr_addr.size() - base), 32'd5);
        chk("over_main_last_addr", 32'(wr_addr[wr_addr.size() - 1]), 32'h10);
        chk("over_main_done", 32'(done), 32'd1);

        // LEN=0x0800 is accepted, then reset arrives in the middle of DATA.
        base = wr_addr.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        for (int j = 1; j <= 9; j++) send_byte(8'(j), 1'b1);
        settle();
        chk("len800_busy", 32'(busy), 32'd1);
        chk("len800_err", 32'(err), 32'd0);
        chk("len800_writes", 32'(wr_addr.size() - base), 32'd2);
        chk("len800_mem_addr", 32'(mem_addr), 32'h4);
        chk("len800_mem_din", mem_din, 32'h0807_0605);
        @(negedge clk);
        rx = 1'b0;
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("midrst_mem_we",    32'(mem_we),    32'd0);
        chk("midrst_mem_addr",  32'(mem_addr),  32'd0);
        chk("midrst_mem_din",   mem_din,        32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_done",      32'(done),      32'd0);
        chk("midrst_err",       32'(err),       32'd0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        base = wr_addr.size();
        cs   = 8'h01 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
`ifdef CHECKSUM_EN
        send_byte(cs, 1'b1);
`endif
        settle();
        cnt = wr_addr.size() - base;
        chk("fresh_writes", 32'(cnt), 32'd1);
        if (cnt > 0) begin
            chk("fresh_addr", 32'(wr_addr[base]), 32'h0);
            chk("fresh_din", wr_din[base], 32'h1234_5678);
        end
        chk("fresh_done", 32'(done), 32'd1);
        chk("fresh_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

        chk("write_pulse_one_cycle", 32'(long_cnt), 32'd0);
        chk("write_enable_all_bytes", 32'(bad_we_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
